// File: rtl/atmega_pll_seq_if.sv
// IO-bus bundle between a bus master (CPU or sequencer) and a register slave.
// rdata is combinational from the slave, valid in the same cycle as rd.
interface atmega_pll_seq_if #(
   parameter int ADDR_W = 16
);
   logic [ADDR_W-1:0] addr;
   logic              wr;
   logic              rd;
   logic [7:0]        wdata;
   logic [7:0]        rdata;

   modport master (output addr, output wr, output rd, output wdata, input rdata);
   modport slave  (input addr, input wr, input rd, input wdata, output rdata);
endinterface

// File: rtl/atmega_pll_seq.sv
// PLL bring-up/shutdown sequencer. It owns the PLL IO bus while sequencing
// and passes CPU accesses through while idle or locked.
module atmega_pll_seq #(
   parameter int                           BUS_ADDR_DATA_LEN = 16,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] PLLCSR_ADDR       = 'h29,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] PLLFRQ_ADDR       = 'h32,
   parameter int                           LOCK_TIMEOUT      = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic [3:0] frq_sel,
   input  logic [1:0] tim_sel,
   input  logic       usb_div2,
   output logic       busy,
   output logic       locked,
   output logic       err,
   output logic       cpu_stall,
   atmega_pll_seq_if.slave  cpu,
   atmega_pll_seq_if.master pll
);

   localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOCK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, WR_FRQ, WR_CSR, POLL, WR_TIM, LOCKED, CLR_TIM, CLR_CSR
   } state_t;

   state_t           state, state_nxt;
   logic [3:0]       cfg_frq;
   logic [1:0]       cfg_tim;
   logic             cfg_usb;
   logic [CNT_W-1:0] cnt;

   logic             cfg_load, err_clr, err_set, cnt_load, cnt_dec;
   logic                         fsm_wr, fsm_rd;
   logic [BUS_ADDR_DATA_LEN-1:0] fsm_addr;
   logic [7:0]                   fsm_wdata;
   logic [7:0]                   frq_word, tim_word;

   // The timer-select field stays 00 until the PLL has locked.
   assign frq_word = {1'b0, cfg_usb, 2'b00, cfg_frq};
   assign tim_word = {1'b0, cfg_usb, cfg_tim, cfg_frq};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cfg_frq <= '0;
         cfg_tim <= '0;
         cfg_usb <= 1'b0;
         cnt     <= '0;
         err     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (cfg_load) begin
            cfg_frq <= frq_sel;
            cfg_tim <= tim_sel;
            cfg_usb <= usb_div2;
         end
         if (cnt_load)     cnt <= CNT_INIT;
         else if (cnt_dec) cnt <= cnt - 1'b1;
         if (err_clr)      err <= 1'b0;
         else if (err_set) err <= 1'b1;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      state_nxt = state;
      cfg_load  = 1'b0;
      err_clr   = 1'b0;
      err_set   = 1'b0;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      fsm_wr    = 1'b0;
      fsm_rd    = 1'b0;
      fsm_addr  = PLLCSR_ADDR;
      fsm_wdata = 8'h00;
      unique case (state)
         IDLE: begin
            if (stop) begin
               state_nxt = CLR_TIM;
            end else if (start) begin
               cfg_load  = 1'b1;
               err_clr   = 1'b1;
               state_nxt = WR_FRQ;
            end
         end
         WR_FRQ: begin
            fsm_wr    = 1'b1;
            fsm_addr  = PLLFRQ_ADDR;
            fsm_wdata = frq_word;
            cnt_load  = 1'b1;
            state_nxt = stop ? CLR_TIM : WR_CSR;
         end
         WR_CSR: begin
            fsm_wr    = 1'b1;
            fsm_wdata = 8'h02;
            state_nxt = stop ? CLR_TIM : POLL;
         end
         POLL: begin
            fsm_rd = 1'b1;
            // An abort takes priority over both lock and timeout.
            if (stop) begin
               state_nxt = CLR_TIM;
            end else if (pll.rdata[0]) begin
               state_nxt = WR_TIM;
            end else if (cnt == '0) begin
               err_set   = 1'b1;
               state_nxt = CLR_CSR;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         WR_TIM: begin
            fsm_wr    = 1'b1;
            fsm_addr  = PLLFRQ_ADDR;
            fsm_wdata = tim_word;
            state_nxt = stop ? CLR_TIM : LOCKED;
         end
         LOCKED: begin
            if (stop) state_nxt = CLR_TIM;
         end
         CLR_TIM: begin
            fsm_wr    = 1'b1;
            fsm_addr  = PLLFRQ_ADDR;
            fsm_wdata = frq_word;
            state_nxt = CLR_CSR;
         end
         CLR_CSR: begin
            fsm_wr    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy      = (state != IDLE) && (state != LOCKED);
   assign locked    = (state == LOCKED);
   assign cpu_stall = busy & (cpu.wr | cpu.rd);

   assign pll.addr  = busy ? fsm_addr  : cpu.addr;
   assign pll.wr    = busy ? fsm_wr    : cpu.wr;
   assign pll.rd    = busy ? fsm_rd    : cpu.rd;
   assign pll.wdata = busy ? fsm_wdata : cpu.wdata;
   assign cpu.rdata = pll.rdata;

endmodule

// File: tb/tb_atmega_pll_seq.sv
// Directed bench for atmega_pll_seq with a small PLL model that raises
// PLOCK after a programmable number of PLLCSR reads.
module tb_atmega_pll_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, stop;
   logic [3:0] frq_sel;
   logic [1:0] tim_sel;
   logic       usb_div2;
   logic       busy, locked, err, cpu_stall;

   int tests  = 0;
   int failed = 0;
   int poll_cnt  = 0;
   int lock_after = 1000;
   logic poll_clr = 1'b0;
   int both_cnt = 0;

   atmega_pll_seq_if #(.ADDR_W(16)) cpu_if ();
   atmega_pll_seq_if #(.ADDR_W(16)) pll_if ();

   atmega_pll_seq #(
      .BUS_ADDR_DATA_LEN(16),
      .PLLCSR_ADDR(16'h0029),
      .PLLFRQ_ADDR(16'h0032),
      .LOCK_TIMEOUT(8)
   ) dut (
      .clk(clk), .rst(rst),
      .start(start), .stop(stop),
      .frq_sel(frq_sel), .tim_sel(tim_sel), .usb_div2(usb_div2),
      .busy(busy), .locked(locked), .err(err), .cpu_stall(cpu_stall),
      .cpu(cpu_if.slave), .pll(pll_if.master)
   );

   always #5 clk = ~clk;

   // PLL model: PLOCK reads back as 1 once lock_after PLLCSR reads have completed.
   always @(posedge clk) begin
      if (poll_clr) poll_cnt <= 0;
      else if (pll_if.rd && pll_if.addr == 16'h0029) poll_cnt <= poll_cnt + 1;
   end
   assign pll_if.rdata = {7'b0, (poll_cnt >= lock_after)};

   always @(negedge clk) if (pll_if.wr && pll_if.rd) both_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_op(input string tag, input logic wr, input logic rd,
                            input logic [15:0] addr, input logic [7:0] wdata);
      logic [7:0] got_d;
      logic [7:0] exp_d;
      got_d = pll_if.rd ? 8'h00 : pll_if.wdata;
      exp_d = rd ? 8'h00 : wdata;
      check(tag, {6'b0, pll_if.wr, pll_if.rd, pll_if.addr, got_d},
                 {6'b0, wr, rd, addr, exp_d});
   endtask

   task automatic expect_status(input string tag, input logic b, input logic l, input logic e);
      check(tag, {29'b0, busy, locked, err}, {29'b0, b, l, e});
   endtask

   task automatic clear_polls();
      poll_clr = 1'b1;
      tick();
      poll_clr = 1'b0;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; stop = 1'b0;
      frq_sel = 4'h0; tim_sel = 2'b00; usb_div2 = 1'b0;
      cpu_if.addr = 16'h0000; cpu_if.wr = 1'b0; cpu_if.rd = 1'b0; cpu_if.wdata = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      expect_status("reset_status", 1'b0, 1'b0, 1'b0);
      check("reset_stall", {31'b0, cpu_stall}, 32'd0);
      rst = 1'b1;
      tick();

      // Bring-up: PLOCK on the third poll; CPU write stalled while sequencing.
      lock_after = 2;
      clear_polls();
      frq_sel = 4'hA; tim_sel = 2'b01; usb_div2 = 1'b1;
      start = 1'b1;
      tick();                                        // c1
      start = 1'b0;
      expect_op("c1_wr_frq", 1'b1, 1'b0, 16'h0032, 8'h4A);
      expect_status("c1_status", 1'b1, 1'b0, 1'b0);
      tick();                                        // c2
      expect_op("c2_wr_csr", 1'b1, 1'b0, 16'h0029, 8'h02);
      tick();                                        // c3
      expect_op("c3_poll", 1'b0, 1'b1, 16'h0029, 8'h00);
      tick();                                        // c4
      cpu_if.addr = 16'h0032; cpu_if.wr = 1'b1; cpu_if.wdata = 8'h77;
      #1;
      check("c4_stall", {31'b0, cpu_stall}, 32'd1);
      expect_op("c4_poll_owned", 1'b0, 1'b1, 16'h0029, 8'h00);
      tick();                                        // c5
      expect_op("c5_poll", 1'b0, 1'b1, 16'h0029, 8'h00);
      tick();                                        // c6
      expect_op("c6_wr_tim", 1'b1, 1'b0, 16'h0032, 8'h5A);
      expect_status("c6_status", 1'b1, 1'b0, 1'b0);
      check("c6_stall", {31'b0, cpu_stall}, 32'd1);
      tick();                                        // c7
      expect_status("c7_locked", 1'b0, 1'b1, 1'b0);
      check("poll_count", poll_cnt, 3);
      check("locked_stall", {31'b0, cpu_stall}, 32'd0);
      expect_op("locked_cpu_wr", 1'b1, 1'b0, 16'h0032, 8'h77);
      cpu_if.wr = 1'b0; cpu_if.rd = 1'b1; cpu_if.addr = 16'h0029;
      #1;
      expect_op("locked_cpu_rd", 1'b0, 1'b1, 16'h0029, 8'h00);
      check("locked_cpu_rdata", {24'b0, cpu_if.rdata}, 32'h01);
      cpu_if.rd = 1'b0;
      tick();
      expect_status("start_ignored_pre", 1'b0, 1'b1, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      expect_status("start_ignored_locked", 1'b0, 1'b1, 1'b0);

      // Shutdown from LOCKED.
      stop = 1'b1;
      tick();
      stop = 1'b0;
      expect_op("stop_clr_tim", 1'b1, 1'b0, 16'h0032, 8'h4A);
      expect_status("stop_status", 1'b1, 1'b0, 1'b0);
      tick();
      expect_op("stop_clr_csr", 1'b1, 1'b0, 16'h0029, 8'h00);
      tick();
      expect_status("stop_idle", 1'b0, 1'b0, 1'b0);

      // Timeout: PLOCK never sets, exactly 8 polls then err.
      lock_after = 1000;
      clear_polls();
      frq_sel = 4'h3; tim_sel = 2'b10; usb_div2 = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      expect_op("to_wr_frq", 1'b1, 1'b0, 16'h0032, 8'h03);
      tick();
      expect_op("to_wr_csr", 1'b1, 1'b0, 16'h0029, 8'h02);
      for (int i = 0; i < 8; i++) begin
         tick();
         expect_op($sformatf("to_poll%0d", i), 1'b0, 1'b1, 16'h0029, 8'h00);
         check($sformatf("to_err_low%0d", i), {31'b0, err}, 32'd0);
      end
      tick();
      expect_op("to_clr_csr", 1'b1, 1'b0, 16'h0029, 8'h00);
      expect_status("to_err_set", 1'b1, 1'b0, 1'b1);
      tick();
      expect_status("to_idle_err", 1'b0, 1'b0, 1'b1);
      check("to_poll_count", poll_cnt, 8);

      // Restart clears err; then abort during POLL.
      start = 1'b1;
      tick();
      start = 1'b0;
      expect_status("restart_err_clr", 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      stop = 1'b1;
      #1;
      expect_op("abort_poll", 1'b0, 1'b1, 16'h0029, 8'h00);
      tick();
      stop = 1'b0;
      expect_op("abort_clr_tim", 1'b1, 1'b0, 16'h0032, 8'h03);
      expect_status("abort_status", 1'b1, 1'b0, 1'b0);
      tick();
      expect_op("abort_clr_csr", 1'b1, 1'b0, 16'h0029, 8'h00);
      tick();
      expect_status("abort_idle", 1'b0, 1'b0, 1'b0);

      // start & stop together in IDLE: shutdown path only, cfg not reloaded.
      frq_sel = 4'hF; usb_div2 = 1'b1;
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      expect_op("ss_clr_tim", 1'b1, 1'b0, 16'h0032, 8'h03);
      tick();
      expect_op("ss_clr_csr", 1'b1, 1'b0, 16'h0029, 8'h00);
      tick();
      expect_status("ss_idle", 1'b0, 1'b0, 1'b0);

      // Asynchronous reset mid-POLL.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      expect_op("rst_pre_poll", 1'b0, 1'b1, 16'h0029, 8'h00);
      rst = 1'b0;
      #1;
      expect_status("rst_async_status", 1'b0, 1'b0, 1'b0);
      check("rst_async_bus", {30'b0, pll_if.wr, pll_if.rd}, 32'd0);
      tick();
      rst = 1'b1;
      tick();
      frq_sel = 4'h5; usb_div2 = 1'b1;
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      expect_op("rst_cfg_cleared", 1'b1, 1'b0, 16'h0032, 8'h00);
      tick();
      tick();
      expect_status("final_idle", 1'b0, 1'b0, 1'b0);

      check("never_wr_and_rd", both_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
